// File: rtl/sdes_key_sched.sv
// S-DES key scheduler: expands a 10-bit key into the two 8-bit round subkeys over
// three cycles (P10, LS-1/P8, LS-2/P8). The decrypt mode swaps the subkeys at load time.
module sdes_key_sched (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       decrypt,
    input  logic       clear,
    input  logic [9:0] key_in,
    output logic [7:0] key_1,
    output logic [7:0] key_2,
    output logic       keys_valid,
    output logic       busy
);

    // Handshake: start is a one-cycle request honoured only in IDLE. keys_valid is a
    // level that holds while key_1/key_2 carry a completed schedule, and it falls on
    // the edge that captures the next start.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PERM = 2'd1,
        RND1 = 2'd2,
        RND2 = 2'd3
    } state_t;

    // Bit 9 is key position 1 (MSB-first), so position p lives at index 10-p.
    function automatic logic [9:0] p10(input logic [9:0] k);
        p10 = {k[7], k[5], k[8], k[3], k[6], k[0], k[9], k[1], k[2], k[4]};
    endfunction

    function automatic logic [7:0] p8(input logic [9:0] k);
        p8 = {k[4], k[7], k[3], k[6], k[2], k[5], k[0], k[1]};
    endfunction

    function automatic logic [9:0] ls1(input logic [9:0] k);
        ls1 = {k[8:5], k[9], k[3:0], k[4]};
    endfunction

    function automatic logic [9:0] ls2(input logic [9:0] k);
        ls2 = {k[7:5], k[9:8], k[2:0], k[4:3]};
    endfunction

    state_t     state_q, state_d;
    logic [9:0] key_r_q, key_r_d;
    logic       mode_r_q, mode_r_d;
    logic [9:0] work_r_q, work_r_d;
    logic [7:0] k1_r_q, k1_r_d;
    logic [7:0] key_1_q, key_1_d;
    logic [7:0] key_2_q, key_2_d;
    logic       valid_q, valid_d;
    logic [7:0] k2_w;

    assign k2_w = p8(ls2(work_r_q));

    always_comb begin
        state_d  = state_q;
        key_r_d  = key_r_q;
        mode_r_d = mode_r_q;
        work_r_d = work_r_q;
        k1_r_d   = k1_r_q;
        key_1_d  = key_1_q;
        key_2_d  = key_2_q;
        valid_d  = valid_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    key_r_d  = key_in;
                    mode_r_d = decrypt;
                    valid_d  = 1'b0;
                    state_d  = PERM;
                end
            end
            PERM: begin
                work_r_d = p10(key_r_q);
                state_d  = RND1;
            end
            RND1: begin
                work_r_d = ls1(work_r_q);
                k1_r_d   = p8(ls1(work_r_q));
                state_d  = RND2;
            end
            RND2: begin
                key_1_d = mode_r_q ? k2_w : k1_r_q;
                key_2_d = mode_r_q ? k1_r_q : k2_w;
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Clear overrides everything, including a start arriving in the same cycle.
        if (clear) begin
            state_d  = IDLE;
            key_r_d  = 10'h000;
            mode_r_d = 1'b0;
            work_r_d = 10'h000;
            k1_r_d   = 8'h00;
            key_1_d  = 8'h00;
            key_2_d  = 8'h00;
            valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            key_r_q  <= 10'h000;
            mode_r_q <= 1'b0;
            work_r_q <= 10'h000;
            k1_r_q   <= 8'h00;
            key_1_q  <= 8'h00;
            key_2_q  <= 8'h00;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            key_r_q  <= key_r_d;
            mode_r_q <= mode_r_d;
            work_r_q <= work_r_d;
            k1_r_q   <= k1_r_d;
            key_1_q  <= key_1_d;
            key_2_q  <= key_2_d;
            valid_q  <= valid_d;
        end
    end

    assign key_1      = key_1_q;
    assign key_2      = key_2_q;
    assign keys_valid = valid_q;
    assign busy       = (state_q != IDLE);

endmodule
